// File: rtl/mmd_pkg.sv
// Shared types, limits and the divide-value clamp for the multi-modulus divider.
// Latency: none (declarations and a pure function only).
// Backpressure: not applicable.
package mmd_pkg;

  localparam int unsigned DIV_W = 4;
  localparam logic [DIV_W-1:0] N_MIN = 4'd3;
  localparam logic [DIV_W-1:0] N_MAX = 4'd11;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Clamped divide value plus a flag saying the raw value was out of range.
  typedef struct packed {
    logic [DIV_W-1:0] n;
    logic             clamped;
  } clamp_t;

  function automatic clamp_t clamp_n(input logic [DIV_W-1:0] raw);
    clamp_t r;
    if (raw < N_MIN) begin
      r.n       = N_MIN;
      r.clamped = 1'b1;
    end else if (raw > N_MAX) begin
      r.n       = N_MAX;
      r.clamped = 1'b1;
    end else begin
      r.n       = raw;
      r.clamped = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/mmd_divider_ratio_meter.sv
// Ratio meter: sums N over 2^WIN_LOG2 divider periods and publishes the sum as 4.WIN_LOG2 fixed point.
// Latency: meas_val/meas_valid update one cycle after the sample that completes a window.
// Backpressure: none; a clear drops the partial window and keeps the last published value.
module ratio_meter
  import mmd_pkg::*;
#(
  parameter int WIN_LOG2 = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr_i,
  input  logic                      smp_i,
  input  logic [DIV_W-1:0]          n_i,
  output logic [DIV_W+WIN_LOG2-1:0] meas_val_o,
  output logic                      meas_vld_o
);

  logic [DIV_W+WIN_LOG2-1:0] acc_q;
  logic [DIV_W+WIN_LOG2-1:0] acc_d;
  logic [WIN_LOG2-1:0]       per_q;
  logic [DIV_W+WIN_LOG2-1:0] meas_val_q;
  logic                      meas_vld_q;
  logic                      wrap;

  // Running sum including the sample being taken now; cannot overflow since 11*2^W < 2^(W+4).
  assign acc_d = acc_q + {{WIN_LOG2{1'b0}}, n_i};
  // The sample taken while the period counter is all-ones completes the window.
  assign wrap  = &per_q;

  // Window accumulation, publication on wrap and clearing of a partial window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q      <= '0;
      per_q      <= '0;
      meas_val_q <= '0;
      meas_vld_q <= 1'b0;
    end else begin
      meas_vld_q <= 1'b0;
      if (clr_i) begin
        acc_q <= '0;
        per_q <= '0;
      end else if (smp_i) begin
        per_q <= per_q + 1'b1;
        if (wrap) begin
          meas_val_q <= acc_d;
          acc_q      <= '0;
          meas_vld_q <= 1'b1;
        end else begin
          acc_q <= acc_d;
        end
      end
    end
  end

  assign meas_val_o = meas_val_q;
  assign meas_vld_o = meas_vld_q;

endmodule

// File: rtl/mmd_divider.sv
// Multi-modulus divider: periods of exactly N clk cycles, N sampled from div_in once per period.
// Latency: div_req/div_out are registered, high the cycle after each sampling edge.
// Backpressure: en low stops the divider only at a period boundary; the period in flight completes.
module mmd_divider
  import mmd_pkg::*;
#(
  parameter int WIN_LOG2 = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [DIV_W-1:0]          div_in,
  output logic                      div_req,
  output logic                      div_out,
  output logic [DIV_W+WIN_LOG2-1:0] meas_val,
  output logic                      meas_valid,
  output logic                      err_range
);

  state_e           state_q;
  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;
  logic [DIV_W-1:0] n_q;
  logic [DIV_W-1:0] hi_min;
  logic             div_req_q;
  logic             div_out_q;
  logic             err_q;
  clamp_t           clp;
  logic             period_end;
  logic             smp;
  logic             stop;

  assign clp        = clamp_n(div_in);
  assign period_end = (state_q == RUN) && (cnt_q == '0);
  // A sample happens on the enabling edge from IDLE and on every period end while enabled.
  assign smp        = en && ((state_q == IDLE) || period_end);
  assign stop       = period_end && !en;
  assign cnt_d      = cnt_q - 4'd1;
  // Cycle k of a period has cnt = N-1-k; k < floor(N/2) is equivalent to cnt >= N - floor(N/2).
  assign hi_min     = n_q - (n_q >> 1);

  // Divider FSM: sampling, down-counting, div_out shaping and sticky range error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      n_q       <= '0;
      div_req_q <= 1'b0;
      div_out_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      div_req_q <= 1'b0;
      if (smp) begin
        state_q   <= RUN;
        cnt_q     <= clp.n - 4'd1;
        n_q       <= clp.n;
        div_req_q <= 1'b1;
        div_out_q <= 1'b1;
        err_q     <= err_q | clp.clamped;
      end else if (stop || (state_q == IDLE)) begin
        state_q   <= IDLE;
        div_out_q <= 1'b0;
      end else begin
        cnt_q     <= cnt_d;
        div_out_q <= (cnt_d >= hi_min);
      end
    end
  end

  ratio_meter #(
    .WIN_LOG2(WIN_LOG2)
  ) u_meter (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (stop),
    .smp_i      (smp),
    .n_i        (clp.n),
    .meas_val_o (meas_val),
    .meas_vld_o (meas_valid)
  );

  assign div_req   = div_req_q;
  assign div_out   = div_out_q;
  assign err_range = err_q;

endmodule

// File: tb/tb_mmd_divider.sv
// Directed bench for mmd_divider with a period-level reference model checked every cycle.
// Latency: outputs compared on the falling edge after each rising edge.
// Backpressure: div_in is re-driven by the bench when it sees div_req.
module tb_mmd_divider;

  localparam int WL = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [3:0]    div_in;
  logic          div_req;
  logic          div_out;
  logic [WL+3:0] meas_val;
  logic          meas_valid;
  logic          err_range;

  int checks = 0;
  int errors = 0;
  bit alt_on = 1'b0;

  mmd_divider #(.WIN_LOG2(WL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .div_in     (div_in),
    .div_req    (div_req),
    .div_out    (div_out),
    .meas_val   (meas_val),
    .meas_valid (meas_valid),
    .err_range  (err_range)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: tracks position k within the current period of length N, counting up.
  bit m_on = 1'b0;
  bit m_run, m_req, m_out, m_mvld, m_err;
  int m_k, m_n, m_cnt, m_sum, m_mval;
  always @(posedge clk) begin
    int raw;
    m_on = 1'b1;
    if (!rst_n) begin
      m_run = 0; m_req = 0; m_out = 0; m_mvld = 0; m_err = 0;
      m_k = 0; m_n = 3; m_cnt = 0; m_sum = 0; m_mval = 0;
    end else begin
      m_req  = 0;
      m_mvld = 0;
      if (m_run && (m_k == m_n - 1) && !en) begin
        m_run = 0; m_cnt = 0; m_sum = 0;
      end else if (en && (!m_run || (m_k == m_n - 1))) begin
        raw = int'(div_in);
        m_n = (raw < 3) ? 3 : ((raw > 11) ? 11 : raw);
        if (raw < 3 || raw > 11) m_err = 1;
        m_run = 1; m_k = 0; m_req = 1;
        m_sum += m_n;
        m_cnt++;
        if (m_cnt == (1 << WL)) begin
          m_mval = m_sum; m_sum = 0; m_cnt = 0; m_mvld = 1;
        end
      end else if (m_run) begin
        m_k++;
      end
      m_out = m_run && (m_k < m_n / 2);
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (m_on) begin
      chk("model_div_req", {31'd0, div_req}, {31'd0, m_req});
      chk("model_div_out", {31'd0, div_out}, {31'd0, m_out});
      chk("model_meas_valid", {31'd0, meas_valid}, {31'd0, m_mvld});
      chk("model_err_range", {31'd0, err_range}, {31'd0, m_err});
      chk("model_meas_val", {24'd0, meas_val}, m_mval);
    end
  end

  // Alternating 5/6 source: next value presented while div_req is high.
  always @(negedge clk) begin
    if (alt_on && div_req) div_in = (div_in == 4'd5) ? 4'd6 : 4'd5;
  end

  task automatic wait_req(input int limit, output int gap);
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (!div_req && gap < limit);
    if (!div_req) chk("req_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_mvld(input int limit, output int gap);
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (!meas_valid && gap < limit);
    if (!meas_valid) chk("meas_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset(input logic [3:0] d);
    rst_n  = 1'b0;
    en     = 1'b1;
    div_in = d;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk(nm, {28'd0, div_req, div_out, meas_valid, err_range}, 32'd0);
    chk(nm, {24'd0, meas_val}, 32'd0);
  endtask

  initial begin
    int g;
    int n;
    logic [4:0] pat;

    // Reset held 3 cycles with en=1, div_in=7.
    rst_n = 1'b0; en = 1'b1; div_in = 4'd7;
    repeat (3) begin
      @(negedge clk);
      chk_all_zero("reset_outputs");
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_req", {31'd0, div_req}, 32'd1);
    wait_req(20, g); chk("gap_n7_a", g, 7);
    wait_req(20, g); chk("gap_n7_b", g, 7);

    // Constant N=5.
    do_reset(4'd5);
    @(negedge clk);
    chk("req_n5", {31'd0, div_req}, 32'd1);
    pat[4] = div_out;
    for (int i = 3; i >= 0; i--) begin
      @(negedge clk);
      pat[i] = div_out;
    end
    chk("div_out_pattern_n5", {27'd0, pat}, 32'b11000);
    wait_mvld(200, g); chk("mval_n5_a", {24'd0, meas_val}, 80);
    wait_mvld(200, g); chk("mval_gap_n5", g, 80);
    chk("mval_n5_b", {24'd0, meas_val}, 80);

    // Alternating 5,6.
    do_reset(4'd5);
    alt_on = 1'b1;
    wait_mvld(300, g); chk("mval_alt_a", {24'd0, meas_val}, 88);
    wait_mvld(300, g); chk("mval_gap_alt", g, 88);
    chk("mval_alt_b", {24'd0, meas_val}, 88);
    alt_on = 1'b0;

    // Out-of-range values 2 then 13.
    do_reset(4'd2);
    @(negedge clk);
    chk("err_after_first", {31'd0, err_range}, 32'd1);
    div_in = 4'd13;
    wait_req(20, g); chk("gap_clamp_lo", g, 3);
    wait_req(20, g); chk("gap_clamp_hi", g, 11);
    chk("err_sticky", {31'd0, err_range}, 32'd1);

    // Enable drop at cycle 4 of a 9-cycle period.
    do_reset(4'd9);
    @(negedge clk);
    wait_req(20, g); chk("gap_n9", g, 9);
    repeat (4) @(negedge clk);
    en = 1'b0;
    n = 0;
    repeat (30) begin
      @(negedge clk);
      if (div_req) n++;
    end
    chk("no_req_after_drop", n, 0);
    chk("div_out_idle", {31'd0, div_out}, 32'd0);
    en = 1'b1;
    wait_mvld(300, g); chk("mval_gap_reenable", g, 136);
    chk("mval_n9", {24'd0, meas_val}, 144);

    // Reset pulse mid-period at cnt=4 (N=11 from a clamped 12).
    do_reset(4'd12);
    @(negedge clk);
    chk("err_before_mid_reset", {31'd0, err_range}, 32'd1);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_all_zero("mid_reset_outputs");
    rst_n = 1'b1;
    @(negedge clk);
    chk("restart_req", {31'd0, div_req}, 32'd1);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmd_divider.md
# mmd_divider

Multi-modulus divider that consumes the 4-bit instantaneous divide value produced by the MASH 1-1-1 delta-sigma modulator. It is the other end of that interface. The block counts `clk` cycles into periods of exactly N, where N is sampled from `div_in` once per period, and emits a divided clock plus a one-cycle request strobe that advances the modulator. An integrated ratio meter sums the N values used over a window of 2^WIN_LOG2 periods and reports the average divide ratio in fixed point, so bench and silicon can check the modulator's mean ratio.

## Interface
- `WIN_LOG2`, 16, log2 of the number of divider periods per measurement window. Use 4 in short simulations.
- `clk` input 1, system clock; the divided clock.
- `rst_n` input 1, reset, synchronous and active-low.
- `en` input 1, run enable.
- `div_in` input 4, divide value N, unsigned; legal range 3..11.
- `div_req` output 1, one-cycle strobe: `div_in` was consumed, present the next value.
- `div_out` output 1, divided clock: high for floor(N/2) cycles, then low for the remainder of each period.
- `meas_val` output 4+WIN_LOG2, sum of N over the last window. Format is unsigned 4.WIN_LOG2 fixed point, equal to the average ratio.
- `meas_valid` output 1, one-cycle strobe: `meas_val` updated.
- `err_range` output 1, sticky: an out-of-range `div_in` was sampled.

## Operation
- Reset is synchronous. At any edge with `rst_n`=0, the block does the following:
  - state <= IDLE.
  - All counters and accumulators are cleared.
  - `div_req`, `div_out`, `meas_valid` and `err_range` go to 0.
  - `meas_val` goes to 0.
- Reset overrides all other activity, including a reset asserted mid-period.
- States:
  - IDLE: all strobes and `div_out` are 0.
  - RUN: counting.
- Transition IDLE -> RUN occurs at an edge where `en`=1. That edge is a sampling edge.
- Sampling edge:
  - `div_in` is captured as N_raw.
  - Clamping: N = 3 if N_raw<3, N = 11 if N_raw>11, else N = N_raw. If N_raw was clamped, `err_range` <= 1 and holds until reset.
  - Down-counter cnt <= N-1.
  - N is latched for `div_out` shaping and is added to the window accumulator.
- In RUN, cnt decrements each cycle. The edge where cnt==0 is the next sampling edge, so consecutive sampling edges are exactly N cycles apart.
- `en`=0 takes effect only at a sampling point. If state is RUN, cnt==0 and `en`=0, the block does not sample, moves to IDLE and generates no `div_req`. The current period always completes.
- On entry to IDLE, the window accumulator and the period counter clear. A partial window produces no `meas_valid`. `meas_val` retains its last value.
- Window arithmetic:
  - acc has width 4+WIN_LOG2 and cannot overflow (11·2^WIN_LOG2 < 2^(4+WIN_LOG2)).
  - A period counter of WIN_LOG2 bits increments per sample.
  - When the sample that wraps the period counter is taken:
    - `meas_val` <= acc + N.
    - acc <= 0.
    - `meas_valid` pulses.

## Timing
- All outputs are registered. None are combinational from inputs.
- `div_req` is high in the single cycle immediately following each sampling edge.
- The source must present the next `div_in`, stable, before the next sampling edge. That edge is at least 3 cycles later.
- `div_out` is high in cycles 0..floor(N/2)-1 of each period, where cycle 0 is the cycle after the sampling edge. It is low otherwise and low in IDLE.
- `meas_valid` coincides with the `div_req` of the window's last period.
- First sampling edge after reset release: the first edge with `rst_n`=1 and `en`=1.
- `div_in` changing between sampling edges has no effect.
- When `en` falls and `rst_n` falls at the same edge, reset wins.

## Structure
- Package `mmd_pkg` holds:
  - DIV_W=4.
  - N_MIN=3.
  - N_MAX=11.
  - State enum {IDLE, RUN}.
  - The clamp function.
- Sub-module `ratio_meter` holds the window accumulator, the period counter, `meas_val` and `meas_valid`. Its inputs are `clk`, `rst_n`, clear, a sample strobe and N.
- The top level holds the FSM, cnt, the clamp and `div_out` shaping.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with `en`=1 and `div_in`=7.
  - All outputs are 0 during reset.
  - The first `div_req` occurs the cycle after the first edge with `rst_n`=1.
  - `div_req` then repeats every 7 cycles.
- Constant N=5 with WIN_LOG2=4:
  - `div_req` every 5 cycles.
  - `div_out` pattern 1,1,0,0,0.
  - `meas_val`=80 (5.0) with `meas_valid` every 80 cycles.
- Alternating 5,6 supplied on each `div_req`:
  - Periods of 5 and 6 cycles.
  - `meas_val`=88 (5.5 in 4.4 format) every 88 cycles.
- Range: `div_in`=2, then 13.
  - Periods of 3 and 11 cycles.
  - `err_range`=1 after the first sample and held until reset.
- Enable drop: N=9, `en`->0 at cycle 4 of a period.
  - The period completes at 9 cycles, then no further `div_req`, and `div_out`=0.
  - On re-enable, there is no `meas_valid` until 16 full new periods.
- Reset mid-period: pulse `rst_n` low for 1 cycle when cnt=4.
  - At the next edge all outputs are 0 and `err_range` is cleared.
  - With `en`=1, sampling restarts at the first edge after release.
